multmod_opseq: RTL and testbench

//  Operand sequencer and result collector for the FPU mantissa multiplier (multmod).

---
 rtl/multmod_opseq_if.sv | 39 +++
 rtl/multmod_opseq.sv | 158 +++++++++++++++
 tb/tb_multmod_opseq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/multmod_opseq_if.sv
// Bus bundle between the multmod operand sequencer and its environment:
// the request side (start/dbl/opa/opb/fpuhold), the multiplier side
// (ma*/mb*/romsel/nx_cyc0_rdy out, multout/movf back) and the result side
// (busy/done/prod/flags). dbg_state exposes the sequencer FSM for checkers.
interface multmod_opseq_if;
  logic        fpuhold;
  logic        start;
  logic        dbl;
  logic [52:0] opa;
  logic [52:0] opb;
  logic [31:0] ma1;
  logic [31:0] mb1;
  logic [20:0] ma0;
  logic [20:0] mb0;
  logic [1:0]  romsel;
  logic        nx_cyc0_rdy;
  logic [31:0] multout;
  logic        movf;
  logic        busy;
  logic        done;
  logic [63:0] prod;
  logic        prod_ovf;
  logic        sticky;
  logic [1:0]  dbg_state;

  // Sequencer view.
  modport slave (
    input  fpuhold, start, dbl, opa, opb, multout, movf,
    output ma1, mb1, ma0, mb0, romsel, nx_cyc0_rdy,
           busy, done, prod, prod_ovf, sticky, dbg_state
  );

  // Environment view (FPU control plus multiplier).
  modport master (
    output fpuhold, start, dbl, opa, opb, multout, movf,
    input  ma1, mb1, ma0, mb0, romsel, nx_cyc0_rdy,
           busy, done, prod, prod_ovf, sticky, dbg_state
  );
endinterface

// File: rtl/multmod_opseq.sv
// multmod_opseq: operand sequencer and result collector for the FPU mantissa
// multiplier. Latches the mantissas on start, issues them over 1 (single) or
// NCYC_DBL (double) cycles, and shifts each multout word into a 64-bit product
// LAT cycles after its issue. fpuhold freezes everything.
// Optional feature macro: MULTMOD_OPSEQ_STICKY_EN (sticky accumulation).
//
// Handshake: start is a level request sampled only in IDLE with fpuhold low;
// it is not queued. busy is high while the operation is in flight, and done
// pulses for one (unheld) cycle with prod/prod_ovf/sticky valid, which then
// hold until the next accepted start clears them.
module multmod_opseq #(
  parameter int LAT      = 2,
  parameter int NCYC_DBL = 4
) (
  input logic            clk,
  input logic            reset_l,
  multmod_opseq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] NLAST_DBL = 2'(NCYC_DBL - 1);

  state_t         state;
  state_t         state_nx;
  logic [52:0]    opa_q;
  logic [52:0]    opb_q;
  logic           dbl_q;
  logic [1:0]     k_q;
  logic [1:0]     n_last_q;
  logic [LAT-1:0] vpipe;
  logic [63:0]    prod_q;
  logic           ovf_q;
  logic           accept;
  logic           issuing;
  logic           cap;

  assign accept  = (state == S_IDLE) && bus.start && !bus.fpuhold;
  assign issuing = (state == S_ISSUE);
  // A capture is due when the oldest pipe stage holds an issue.
  assign cap     = vpipe[LAT-1];

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; a held cycle keeps the current state.
  always_comb begin
    state_nx = state;
    if (!bus.fpuhold) begin
      case (state)
        S_IDLE:  if (bus.start) state_nx = S_ISSUE;
        S_ISSUE: if (k_q == n_last_q) state_nx = S_DRAIN;
        S_DRAIN: if (vpipe == '0) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Operand latch and issue index counter.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      opa_q    <= '0;
      opb_q    <= '0;
      dbl_q    <= 1'b0;
      k_q      <= '0;
      n_last_q <= '0;
    end else if (!bus.fpuhold) begin
      if (accept) begin
        opa_q    <= bus.opa;
        opb_q    <= bus.opb;
        dbl_q    <= bus.dbl;
        n_last_q <= bus.dbl ? NLAST_DBL : 2'd0;
        k_q      <= '0;
      end else if (issuing) begin
        k_q <= k_q + 2'd1;
      end
    end
  end

  // Valid pipe: one bit per issue, emerging LAT cycles later.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)          vpipe <= '0;
    else if (!bus.fpuhold) vpipe <= LAT'({vpipe, issuing});
  end

  // Product assembly: each capture shifts a word in from the top.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!bus.fpuhold) begin
      if (accept) begin
        prod_q <= '0;
        ovf_q  <= 1'b0;
      end else if (cap) begin
        prod_q <= {bus.multout, prod_q[63:32]};
        ovf_q  <= ovf_q | bus.movf;
      end
    end
  end

`ifdef MULTMOD_OPSEQ_STICKY_EN
  logic sticky_q;

  // Sticky collects any nonzero bits pushed out of the low product word.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sticky_q <= 1'b0;
    end else if (!bus.fpuhold) begin
      if (accept)   sticky_q <= 1'b0;
      else if (cap) sticky_q <= sticky_q | (|prod_q[31:0]);
    end
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  // Multiplier-facing slices, driven only while issuing.
  always_comb begin
    bus.ma1         = '0;
    bus.ma0         = '0;
    bus.mb1         = '0;
    bus.mb0         = '0;
    bus.romsel      = '0;
    bus.nx_cyc0_rdy = 1'b0;
    if (issuing) begin
      bus.romsel      = k_q;
      bus.nx_cyc0_rdy = (k_q == 2'd0);
      if (dbl_q) begin
        bus.ma1 = opa_q[52:21];
        bus.ma0 = opa_q[20:0];
        bus.mb1 = opb_q[52:21];
        bus.mb0 = opb_q[20:0];
      end else begin
        bus.ma1 = {opa_q[23:0], 8'h00};
        bus.mb1 = {opb_q[23:0], 8'h00};
      end
    end
  end

  assign bus.busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign bus.done      = (state == S_DONE);
  assign bus.prod      = prod_q;
  assign bus.prod_ovf  = ovf_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_multmod_opseq.sv
// Bench for multmod_opseq: a stub multiplier returns issue index + 1 after LAT
// cycles (movf from a per-operation mask, forced high when no capture is due),
// and a reference model builds the expected product from the list of returned
// words. Directed cases first, then randomized operations.
module tb_multmod_opseq;
  localparam int LAT      = 2;
  localparam int NCYC_DBL = 4;

  logic clk     = 1'b0;
  logic reset_l = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic [3:0] ovf_mask = 4'h0;

  multmod_opseq_if bus();

  multmod_opseq #(.LAT(LAT), .NCYC_DBL(NCYC_DBL)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  // Clock.
  always #5 clk = ~clk;

  // Stub multiplier: tags each issue with romsel, frozen by fpuhold like the FPU.
  logic [1:0]     tag_p [LAT];
  logic [LAT-1:0] vld_p;
  logic           stub_vld;
  assign stub_vld = bus.busy && ((bus.romsel != 2'd0) || bus.nx_cyc0_rdy);

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      vld_p <= '0;
      for (int i = 0; i < LAT; i++) tag_p[i] <= 2'd0;
    end else if (!bus.fpuhold) begin
      vld_p    <= LAT'({vld_p, stub_vld});
      tag_p[0] <= bus.romsel;
      for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign bus.multout = vld_p[LAT-1] ? (32'(tag_p[LAT-1]) + 32'd1) : 32'hDEAD_BEEF;
  assign bus.movf    = vld_p[LAT-1] ? ovf_mask[tag_p[LAT-1]] : 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: words 1..n enter a 64-bit window from the top; whatever falls
  // below the window feeds sticky.
  task automatic model(input int n, input logic [3:0] mask,
                       output logic [63:0] p, output logic o, output logic s);
    logic [191:0] stream;
    stream = '0;
    for (int i = 0; i < n; i++) stream[64 + 32*i +: 32] = 32'(i + 1);
    p = 64'(stream >> (32 * n));
    o = |(mask & 4'((1 << n) - 1));
`ifdef MULTMOD_OPSEQ_STICKY_EN
    s = ((stream << (192 - 32 * n)) != '0);
`else
    s = 1'b0;
`endif
  endtask

  task automatic chk_zero_outs(input string pfx);
    chk({pfx, "_busy"}, 64'(bus.busy), 64'd0);
    chk({pfx, "_done"}, 64'(bus.done), 64'd0);
    chk({pfx, "_romsel"}, 64'(bus.romsel), 64'd0);
    chk({pfx, "_nx"}, 64'(bus.nx_cyc0_rdy), 64'd0);
    chk({pfx, "_ma"}, {bus.ma1, 11'd0, bus.ma0}, 64'd0);
    chk({pfx, "_mb"}, {bus.mb1, 11'd0, bus.mb0}, 64'd0);
    chk({pfx, "_prod"}, bus.prod, 64'd0);
    chk({pfx, "_flags"}, {62'd0, bus.prod_ovf, bus.sticky}, 64'd0);
  endtask

  // One operation, checked every cycle. hold_at/spur_at are effective cycle
  // numbers after the start edge (-1 = none); keep leaves start high.
  task automatic run_op(input logic d, input logic [52:0] a, input logic [52:0] b,
                        input logic [3:0] mask, input int hold_at, input int hold_len,
                        input int spur_at, input logic keep);
    int n, fin, eff, held;
    logic [63:0] e_prod;
    logic e_ovf, e_sticky;
    logic [31:0] e_ma1, e_mb1;
    logic [20:0] e_ma0, e_mb0;
    n    = d ? NCYC_DBL : 1;
    fin  = n + LAT + 1;
    eff  = 0;
    held = 0;
    model(n, mask, e_prod, e_ovf, e_sticky);
    e_ma1 = d ? 32'(a >> 21) : 32'((a & 53'hFF_FFFF) << 8);
    e_mb1 = d ? 32'(b >> 21) : 32'((b & 53'hFF_FFFF) << 8);
    e_ma0 = d ? 21'(a & 53'h1F_FFFF) : 21'd0;
    e_mb0 = d ? 21'(b & 53'h1F_FFFF) : 21'd0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    bus.start   = 1'b1;
    bus.dbl     = d;
    bus.opa     = a;
    bus.opb     = b;
    bus.fpuhold = 1'b0;
    ovf_mask    = mask;
    for (int cyc = 0; cyc < fin + hold_len + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("clr_prod", bus.prod, 64'd0);
        chk("clr_flags", {62'd0, bus.prod_ovf, bus.sticky}, 64'd0);
        bus.opa = {$urandom, $urandom};
        bus.opb = {$urandom, $urandom};
        bus.dbl = ~d;
      end
      if (eff < n) begin
        chk("iss_romsel", 64'(bus.romsel), 64'(eff));
        chk("iss_nx", 64'(bus.nx_cyc0_rdy), 64'(eff == 0));
        chk("iss_ma1", 64'(bus.ma1), 64'(e_ma1));
        chk("iss_ma0", 64'(bus.ma0), 64'(e_ma0));
        chk("iss_mb1", 64'(bus.mb1), 64'(e_mb1));
        chk("iss_mb0", 64'(bus.mb0), 64'(e_mb0));
        chk("iss_busy", 64'(bus.busy), 64'd1);
        chk("iss_done", 64'(bus.done), 64'd0);
      end else if (eff < fin) begin
        chk("drn_busy", 64'(bus.busy), 64'd1);
        chk("drn_done", 64'(bus.done), 64'd0);
        chk("drn_issue", {bus.ma1, 9'd0, bus.romsel, bus.nx_cyc0_rdy, bus.ma0}, 64'd0);
      end else begin
        chk("done", 64'(bus.done), 64'd1);
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("prod", bus.prod, e_prod);
        chk("prod_ovf", 64'(bus.prod_ovf), 64'(e_ovf));
        chk("sticky", 64'(bus.sticky), 64'(e_sticky));
      end
      bus.start = keep || (eff == spur_at);
      if (eff == hold_at && held < hold_len) begin
        bus.fpuhold = 1'b1;
        held++;
      end else begin
        bus.fpuhold = 1'b0;
        if (eff == fin) break;
        eff++;
      end
    end
  endtask

  // Directed and random stimulus.
  initial begin
    logic [52:0] ones;
    ones        = 53'h1F_FFFF_FFFF_FFFF;
    bus.start   = 1'b0;
    bus.dbl     = 1'b0;
    bus.opa     = '0;
    bus.opb     = '0;
    bus.fpuhold = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outs("rst");
    reset_l = 1'b1;

    // Single: one issue, done at +4.
    run_op(1'b0, 53'hC0_0001, 53'h80_00FF, 4'h0, -1, 0, -1, 1'b0);
    // Double: four issues, done at +7.
    run_op(1'b1, ones, 53'h0A_5A5A_5A5A_5A5A, 4'h0, -1, 0, -1, 1'b0);
    // Hold three cycles during issue k=1: done at +10.
    run_op(1'b1, ones, ones, 4'h0, 1, 3, -1, 1'b0);
    // Overflow on second capture only, spurious start while busy.
    run_op(1'b1, 53'h12_3456_789A_BCDE, 53'h0F_EDCB_A987_6543, 4'b0010, -1, 0, 2, 1'b0);
    // Hold while done is high stretches it.
    run_op(1'b0, 53'h00_0000_00FF_FFFF, 53'h1, 4'h1, LAT + 2, 2, -1, 1'b0);
    // Back-to-back with start held; results cleared between operations.
    run_op(1'b1, ones, ones, 4'hF, -1, 0, -1, 1'b1);
    run_op(1'b0, 53'h00_0000_0055_AA55, 53'h7, 4'h0, -1, 0, -1, 1'b0);
    bus.start = 1'b0;

    // Reset mid-double, after some captures.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dbl   = 1'b1;
    bus.opa   = ones;
    bus.opb   = ones;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_prod_nz", 64'(bus.prod != 64'd0), 64'd1);
    reset_l = 1'b0;
    #1;
    chk_zero_outs("midrst");
    @(negedge clk);
    reset_l = 1'b1;
    run_op(1'b1, ones, ones, 4'h0, -1, 0, -1, 1'b0);

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      logic d, keep;
      int fin, h_at, h_len, s_at;
      d     = 1'($urandom_range(0, 1));
      fin   = (d ? NCYC_DBL : 1) + LAT + 1;
      h_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, fin)) : -1;
      h_len = (h_at >= 0) ? int'($urandom_range(1, 3)) : 0;
      s_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, fin - 1)) : -1;
      keep  = (t != 39) && ($urandom_range(0, 3) == 0);
      run_op(d, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
             h_at, h_len, s_at, keep);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("end_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end
endmodule
